// File: rtl/riscv_pkg.sv
// Shared definitions for the data- and instruction-side memory bridges.
// Holds the bridge FSM encoding and the default error read word.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/data_mem_bridge.sv
// Data-side bridge: turns held core load/store requests into a
// req/ack memory transaction, stalling the core until completion.
module data_mem_bridge
    import riscv_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dram_read,
    input  logic        dram_write,
    input  logic [31:0] dram_addr,
    input  logic [31:0] dram_data_out,
    output logic [31:0] dram_data_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    mem_state_e    state;
    logic [CW-1:0] cnt;
    logic          req_any;

    assign req_any = dram_read | dram_write;
    assign stall   = (state == BUSY) || ((state == IDLE) && req_any);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            dram_data_in <= '0;
            err          <= 1'b0;
            cnt          <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_any) begin
                        mem_addr  <= dram_addr;
                        mem_wdata <= dram_data_out;
                        // a read+write conflict resolves to the write
                        mem_we    <= dram_write;
                        mem_req   <= 1'b1;
                        cnt       <= '0;
                        state     <= BUSY;
                        if (dram_read && dram_write)
                            err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        if (!mem_we)
                            dram_data_in <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        if (!mem_we)
                            dram_data_in <= ERR_DATA;
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        cnt     <= cnt + CW'(1);
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_bridge.md
DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles waiting for mem_ack before abort.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF: read data returned on timeout.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 dram_read  input  1  core load request, held until stall low.
REQ-006 dram_write  input  1  core store request, held until stall low.
REQ-007 dram_addr  input  32  core word address.
REQ-008 dram_data_out  input  32  core store data.
REQ-009 dram_data_in  output  32  load data to core.
REQ-010 stall  output  1  freeze core PC/register writeback while high.
REQ-011 mem_req  output  1  memory-side request, held until ack.
REQ-012 mem_we  output  1  1 = write, 0 = read; valid with mem_req.
REQ-013 mem_addr  output  32  registered word address.
REQ-014 mem_wdata  output  32  registered write data.
REQ-015 mem_rdata  input  32  read data, valid in the cycle mem_ack=1.
REQ-016 mem_ack  input  1  single-cycle completion pulse.
REQ-017 err  output  1  sticky: timeout or read+write conflict seen.

Function
REQ-018 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-019 IDLE: on (dram_read|dram_write) capture addr, wdata, we into mem_* registers, go BUSY next edge.
REQ-020 stall = 1 in IDLE when dram_read|dram_write, and throughout BUSY; stall = 0 in DONE and idle-without-request (combinational).
REQ-021 BUSY: mem_req=1; mem_addr/mem_we/mem_wdata stable until ack or timeout.
REQ-022 BUSY with mem_ack=1: latch mem_rdata into dram_data_in (reads only), go DONE; mem_req low in the following cycle.
REQ-023 DONE lasts exactly one cycle (core commits), then IDLE unconditionally; no request captured in DONE.
REQ-024 Minimum latency: request in cycle N, ack in N+1, stall low in N+2.
REQ-025 Wait counter clears on entering BUSY, +1 per BUSY cycle without ack; reaching TIMEOUT -> dram_data_in=ERR_DATA (read), err=1, go DONE, mem_req dropped.
REQ-026 Ack in the same cycle the counter reaches TIMEOUT counts as success.
REQ-027 Read and write both high in IDLE: perform write, set err.
REQ-028 mem_ack outside BUSY ignored; no state or data change.
REQ-029 Writes leave dram_data_in unchanged.
REQ-030 err clears only on reset.

Reset
REQ-031 reset=0 asynchronously forces state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dram_data_in=0, err=0, counter=0.
REQ-032 Reset mid-BUSY aborts the access immediately; no DONE cycle, no data latched.
REQ-033 After release, first request is accepted at the first rising edge with reset=1.

Structure
REQ-034 FSM state encoding and ERR_DATA default live in a shared package (riscv_pkg) for reuse by the instruction-side bridge.
REQ-035 Single flat module; the wait counter is inline, no sub-module.

Verification
REQ-036 Read addr 0x10, ack after 3 BUSY cycles with rdata 0xCAFE0001 -> stall high 4 cycles, dram_data_in=0xCAFE0001 in DONE, mem_req high exactly 3 cycles.
REQ-037 Write addr 0x20 data 0x12345678, ack next cycle -> mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 held, dram_data_in unchanged, stall low at N+2.
REQ-038 Read with no ack, TIMEOUT=4 -> after 4 BUSY cycles dram_data_in=0xDEADBEEF, err=1, mem_req low; err stays 1 across later good accesses.
REQ-039 Read and write asserted together -> write performed, err=1.
REQ-040 Reset asserted in 2nd BUSY cycle -> all outputs zero same cycle, state IDLE, later ack ignored.
REQ-041 Back-to-back reads held by core -> each access separated by one DONE cycle, no duplicate mem_req for the same instruction.
